// File: rtl/stack_sequencer.sv
// Call/return sequencer driving a downstream shift-register stack through SETUP/SHIFT/DONE.
// Define STK_GUARD_EN to suppress the strobe on a push into a full stack (default: oldest entry is dropped).
module stack_sequencer #(
    parameter int DEPTH_MAX = 4
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       call_req_i,
    input  logic       ret_req_i,
    input  logic [9:0] pc_in_i,
    input  logic [9:0] sp_in_i,
    output logic       mode1_o,
    output logic       mode0_o,
    output logic       stk_en_o,
    output logic [9:0] pc_out_o,
    output logic       call_ack_o,
    output logic       ret_ack_o,
    output logic [9:0] ret_addr_o,
    output logic [2:0] depth_o,
    output logic       ovf_o,
    output logic       unf_o,
    output logic       busy_o,
    output logic [1:0] state_o
);

    // Handshake: a request is held high until its ACK pulse; it is sampled only in IDLE,
    // CALL has priority, and dropping a request after acceptance does not abort the operation.
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] DMAX = 3'(DEPTH_MAX);
`ifdef STK_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    state_t     state_q;
    logic       op_pop_q;
    logic [1:0] mode_q;
    logic       stk_en_q;
    logic [9:0] pc_out_q;
    logic [9:0] ret_addr_q;
    logic       call_ack_q;
    logic       ret_ack_q;
    logic [2:0] depth_q;
    logic       ovf_q;
    logic       unf_q;

    logic full;
    logic empty;
    logic skip;

    assign full  = (depth_q == DMAX);
    assign empty = (depth_q == 3'd0);
    // Underflow always skips the strobe; overflow only skips it when guarded.
    assign skip  = op_pop_q ? empty : (full & GUARD);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= IDLE;
            op_pop_q   <= 1'b0;
            mode_q     <= 2'b00;
            stk_en_q   <= 1'b0;
            pc_out_q   <= '0;
            ret_addr_q <= '0;
            call_ack_q <= 1'b0;
            ret_ack_q  <= 1'b0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            stk_en_q   <= 1'b0;
            call_ack_q <= 1'b0;
            ret_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (call_req_i) begin
                        pc_out_q <= pc_in_i;
                        op_pop_q <= 1'b0;
                        mode_q   <= 2'b10;
                        state_q  <= SETUP;
                    end else if (ret_req_i) begin
                        ret_addr_q <= sp_in_i;
                        op_pop_q   <= 1'b1;
                        mode_q     <= 2'b11;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    state_q  <= SHIFT;
                    stk_en_q <= ~skip;
                    if (op_pop_q) begin
                        if (empty) unf_q <= 1'b1;
                        else       depth_q <= depth_q - 3'd1;
                    end else begin
                        if (full) ovf_q <= 1'b1;
                        else      depth_q <= depth_q + 3'd1;
                    end
                end
                SHIFT: begin
                    state_q <= DONE;
                    mode_q  <= 2'b00;
                    if (op_pop_q) ret_ack_q  <= 1'b1;
                    else          call_ack_q <= 1'b1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mode1_o    = mode_q[1];
    assign mode0_o    = mode_q[0];
    assign stk_en_o   = stk_en_q;
    assign pc_out_o   = pc_out_q;
    assign ret_addr_o = ret_addr_q;
    assign call_ack_o = call_ack_q;
    assign ret_ack_o  = ret_ack_q;
    assign depth_o    = depth_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign busy_o     = (state_q != IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: push/pop timing, priority, full/empty boundaries, reset abort.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       call_req = 1'b0;
    logic       ret_req = 1'b0;
    logic [9:0] pc_in = '0;
    logic [9:0] sp_in = '0;
    logic       mode1, mode0, stk_en, call_ack, ret_ack, ovf, unf, busy;
    logic [9:0] pc_out, ret_addr;
    logic [2:0] depth;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

`ifdef STK_GUARD_EN
    localparam logic FULL_STB = 1'b0;
`else
    localparam logic FULL_STB = 1'b1;
`endif

    stack_sequencer #(.DEPTH_MAX(4)) dut (
        .clk_i(clk), .nrst_i(nrst), .call_req_i(call_req), .ret_req_i(ret_req),
        .pc_in_i(pc_in), .sp_in_i(sp_in), .mode1_o(mode1), .mode0_o(mode0),
        .stk_en_o(stk_en), .pc_out_o(pc_out), .call_ack_o(call_ack), .ret_ack_o(ret_ack),
        .ret_addr_o(ret_addr), .depth_o(depth), .ovf_o(ovf), .unf_o(unf),
        .busy_o(busy), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        call_req = 1'b0;
        ret_req = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    // One full request: SETUP, SHIFT, DONE, then back to IDLE after the request drops.
    task automatic run_op(input string tag, input logic is_call, input logic [9:0] data,
                          input logic exp_stb, input logic [2:0] exp_depth);
        logic [1:0] exp_mode;
        exp_mode = is_call ? 2'b10 : 2'b11;
        if (is_call) begin call_req = 1'b1; pc_in = data; end
        else         begin ret_req = 1'b1;  sp_in = data; end
        tick();
        chk({tag, " setup mode"}, {mode1, mode0}, exp_mode);
        chk({tag, " setup stk_en"}, stk_en, 1'b0);
        chk({tag, " setup busy"}, busy, 1'b1);
        tick();
        chk({tag, " shift mode"}, {mode1, mode0}, exp_mode);
        chk({tag, " shift stk_en"}, stk_en, exp_stb);
        chk({tag, " shift depth"}, depth, exp_depth);
        tick();
        chk({tag, " done acks"}, {call_ack, ret_ack}, is_call ? 2'b10 : 2'b01);
        chk({tag, " done mode"}, {mode1, mode0}, 2'b00);
        chk({tag, " done data"}, is_call ? pc_out : ret_addr, data);
        call_req = 1'b0;
        ret_req = 1'b0;
        tick();
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle acks"}, {call_ack, ret_ack}, 2'b00);
    endtask

    initial begin
        nrst = 1'b0;
        tick();
        chk("reset mode", {mode1, mode0}, 2'b00);
        chk("reset stk_en", stk_en, 1'b0);
        chk("reset acks", {call_ack, ret_ack}, 2'b00);
        chk("reset pc_out", pc_out, 10'h000);
        chk("reset ret_addr", ret_addr, 10'h000);
        chk("reset depth", depth, 3'd0);
        chk("reset flags", {ovf, unf}, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset state", state, 2'd0);
        nrst = 1'b1;

        // Request raised in the first cycle after reset release.
        run_op("push155", 1'b1, 10'h155, 1'b1, 3'd1);

        do_reset();
        run_op("push1", 1'b1, 10'h001, 1'b1, 3'd1);
        run_op("push2", 1'b1, 10'h002, 1'b1, 3'd2);
        run_op("push3", 1'b1, 10'h003, 1'b1, 3'd3);
        run_op("pop3", 1'b0, 10'h003, 1'b1, 3'd2);
        run_op("pop2", 1'b0, 10'h002, 1'b1, 3'd1);

        // Simultaneous requests at depth 1: push first, pop served afterwards.
        call_req = 1'b1; pc_in = 10'h0AA;
        ret_req = 1'b1;  sp_in = 10'h0BB;
        tick();
        chk("both setup mode", {mode1, mode0}, 2'b10);
        tick();
        chk("both push stk_en", stk_en, 1'b1);
        chk("both push depth", depth, 3'd2);
        tick();
        chk("both push acks", {call_ack, ret_ack}, 2'b10);
        chk("both pc_out", pc_out, 10'h0AA);
        call_req = 1'b0;
        tick();
        chk("both gap state", state, 2'd0);
        tick();
        chk("both pop mode", {mode1, mode0}, 2'b11);
        tick();
        chk("both pop stk_en", stk_en, 1'b1);
        chk("both pop depth", depth, 3'd1);
        tick();
        chk("both pop acks", {call_ack, ret_ack}, 2'b01);
        chk("both ret_addr", ret_addr, 10'h0BB);
        ret_req = 1'b0;
        tick();

        run_op("pop1", 1'b0, 10'h001, 1'b1, 3'd0);
        chk("pre-empty unf", unf, 1'b0);
        run_op("pop_empty", 1'b0, 10'h077, 1'b0, 3'd0);
        chk("empty unf", unf, 1'b1);
        chk("empty ovf", ovf, 1'b0);
        tick();
        chk("unf sticky", unf, 1'b1);

        do_reset();
        chk("unf cleared", unf, 1'b0);
        run_op("fill1", 1'b1, 10'h011, 1'b1, 3'd1);
        run_op("fill2", 1'b1, 10'h022, 1'b1, 3'd2);
        run_op("fill3", 1'b1, 10'h033, 1'b1, 3'd3);
        run_op("fill4", 1'b1, 10'h044, 1'b1, 3'd4);
        chk("full no ovf yet", ovf, 1'b0);
        run_op("fill5", 1'b1, 10'h055, FULL_STB, 3'd4);
        chk("full ovf", ovf, 1'b1);
        run_op("pop_after_full", 1'b0, 10'h055, 1'b1, 3'd3);
        chk("ovf sticky", ovf, 1'b1);

        // Reset asserted while the strobe is high.
        do_reset();
        call_req = 1'b1; pc_in = 10'h3C3;
        tick();
        tick();
        chk("abort pre stk_en", stk_en, 1'b1);
        nrst = 1'b0;
        #1;
        chk("abort stk_en", stk_en, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort depth", depth, 3'd0);
        chk("abort acks", {call_ack, ret_ack}, 2'b00);
        call_req = 1'b0;
        tick();
        tick();
        chk("abort held acks", {call_ack, ret_ack}, 2'b00);
        chk("abort pc_out", pc_out, 10'h000);
        nrst = 1'b1;
        tick();
        chk("abort idle", state, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter DEPTH_MAX, default 4: number of stack levels in the downstream shift-register stack.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 NRST  input  1  reset, asynchronous and active-low.
REQ-004 CALL_REQ  input  1  push request; held high until CALL_ACK.
REQ-005 RET_REQ  input  1  pop request; held high until RET_ACK.
REQ-006 PC_IN  input  10  return address to push, sampled on CALL accept.
REQ-007 SP_IN  input  10  top-of-stack from the stack datapath.
REQ-008 MODE1, MODE0  output  1 each  stack mode: 10 push, 11 pop, 00 hold.
REQ-009 STK_EN  output  1  single-cycle shift strobe to the stack datapath.
REQ-010 PC_OUT  output  10  latched push address driven to the stack datapath.
REQ-011 CALL_ACK, RET_ACK  output  1 each  single-cycle completion pulses.
REQ-012 RET_ADDR  output  10  popped address, valid in the RET_ACK cycle and held until the next pop.
REQ-013 DEPTH  output  3  current occupancy, 0..DEPTH_MAX.
REQ-014 OVF, UNF  output  1 each  sticky overflow/underflow flags.
REQ-015 BUSY  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT and DONE.
REQ-017 In IDLE with CALL_REQ=1, the FSM SHALL latch PC_IN into PC_OUT and go to SETUP with op=push.
REQ-018 In IDLE with RET_REQ=1 and CALL_REQ=0, the FSM SHALL latch RET_ADDR<=SP_IN, then go to SETUP with op=pop.
REQ-019 When CALL_REQ and RET_REQ are high together, CALL SHALL win; RET stays pending and is served afterwards.
REQ-020 In SETUP, MODE1/MODE0 SHALL show the op code (10 or 11) with STK_EN=0, so mode is stable one cycle before the strobe.
REQ-021 In SHIFT, STK_EN=1 for exactly one cycle with the mode unchanged; DEPTH updates on the same edge.
REQ-022 In DONE, the matching ACK SHALL pulse for one cycle, mode returns to 00 and the FSM returns to IDLE.
REQ-023 Latency from request sampled to ACK SHALL be 3 cycles; a new request is not accepted before the cycle after DONE.
REQ-024 A push at DEPTH<DEPTH_MAX SHALL increment DEPTH.
REQ-025 A pop at DEPTH>0 SHALL decrement DEPTH.
REQ-026 A pop at DEPTH=0 SHALL skip the SHIFT strobe (STK_EN stays 0) and set UNF; RET_ACK still pulses and RET_ADDR still updates.
REQ-027 A push at DEPTH=DEPTH_MAX SHALL follow REQ-036/REQ-037.
REQ-028 MODE1/MODE0 SHALL be 00 and STK_EN SHALL be 0 in IDLE.
REQ-029 Requests deasserted before an ACK SHALL NOT abort an operation in flight.
REQ-030 OVF and UNF SHALL clear only on reset.

Reset
REQ-031 On NRST=0 the FSM SHALL go to IDLE immediately.
REQ-032 On NRST=0: DEPTH=0; OVF=UNF=0; MODE1=MODE0=0; STK_EN=0; ACKs=0; PC_OUT=0; RET_ADDR=0; BUSY=0.
REQ-033 Reset mid-operation SHALL abort the operation with no ACK and no STK_EN glitch.
REQ-034 The stack datapath contents after a reset SHALL be treated as invalid, since DEPTH=0.
REQ-035 The first cycle after NRST rises SHALL accept requests.

Configuration
REQ-036 With STK_GUARD_EN defined, a push at DEPTH=DEPTH_MAX SHALL:
- skip the strobe (STK_EN stays 0);
- leave DEPTH unchanged;
- set OVF;
- still pulse CALL_ACK.
REQ-037 Without STK_GUARD_EN, a push at DEPTH=DEPTH_MAX SHALL:
- strobe normally, dropping the oldest entry;
- keep DEPTH at DEPTH_MAX;
- set OVF.

Verification
REQ-038 Push: CALL_REQ with PC_IN=0x155 from reset -> SETUP shows MODE=10, next cycle STK_EN=1 and PC_OUT=0x155, CALL_ACK 3 cycles after the request, DEPTH=1.
REQ-039 Pop: push 0x001/0x002/0x003, then RET_REQ with SP_IN=0x003 -> MODE=11 for SETUP+SHIFT, RET_ADDR=0x003 at RET_ACK, DEPTH=2.
REQ-040 Simultaneous CALL_REQ+RET_REQ at DEPTH=1 -> push done first (DEPTH=2), then pop (DEPTH=1), each with its own ACK.
REQ-041 Full stack: five pushes -> with STK_GUARD_EN, the fifth has no STK_EN, DEPTH=4, OVF=1; without it, the fifth strobes, DEPTH=4, OVF=1.
REQ-042 Empty stack: RET_REQ at DEPTH=0 -> no STK_EN, UNF=1, RET_ACK pulses, DEPTH=0.
REQ-043 Reset mid-op: NRST low during SHIFT -> STK_EN drops at once, no ACK, DEPTH=0, BUSY=0.
